// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file: default geometry,
// address-width derivation and the value rows take on reset.
package regfile_pkg;

   localparam int DEF_WIDTH = 13;
   localparam int DEF_DEPTH = 8;
   localparam int RST_VAL   = 0;

   // A depth of one would give $clog2 == 0, so keep at least one address bit
   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/regfile_row_p.sv
// One storage row of the register file: a WIDTH-bit register with
// synchronous clear and load enable.
module regfile_row_p
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset)
         q <= WIDTH'(RST_VAL);
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/regfile_pipe.sv
// Register file with two registered read ports, one write port and a pending
// scoreboard. Define REGFILE_PIPE_BYPASS_EN for write-through on the read ports.
module regfile_pipe
   import regfile_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = calc_aw(DEPTH)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [AW-1:0]    RP,
   input  logic [AW-1:0]    RQ,
   input  logic [AW-1:0]    WA,
   input  logic [WIDTH-1:0] LD_DATA,
   input  logic             WR,
   input  logic             RSV,
   input  logic [AW-1:0]    RSV_A,
   output logic [WIDTH-1:0] DATAP,
   output logic [WIDTH-1:0] DATAQ,
   output logic             PENDP,
   output logic             PENDQ,
   output logic [AW:0]      PEND_CNT
);

   logic [WIDTH-1:0] row_q [DEPTH];
   logic [DEPTH-1:0] wr_dec;
   logic [DEPTH-1:0] rsv_dec;
   logic [DEPTH-1:0] pend;
   logic [DEPTH-1:0] pend_next;
   logic [AW:0]      cnt_next;
   logic [WIDTH-1:0] rd_data_p;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_pend_p;
   logic             rd_pend_q;

   // Addresses at or beyond DEPTH never match a row, so they fall out as no-ops
   always_comb begin
      wr_dec  = '0;
      rsv_dec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_dec[i]  = WR  && (WA    == AW'(i));
         rsv_dec[i] = RSV && (RSV_A == AW'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      regfile_row_p #(.WIDTH(WIDTH)) u_row (
         .clock (CLK),
         .reset (CLR),
         .ld    (wr_dec[g]),
         .d     (LD_DATA),
         .q     (row_q[g])
      );
   end

   // Reserve is applied after the write clear so a new producer supersedes
   always_comb begin
      pend_next = pend;
      cnt_next  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_dec[i])
            pend_next[i] = 1'b0;
         if (rsv_dec[i])
            pend_next[i] = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++)
         cnt_next = cnt_next + {{AW{1'b0}}, pend_next[i]};
   end

   always_comb begin
      rd_data_p = '0;
      rd_data_q = '0;
      rd_pend_p = 1'b0;
      rd_pend_q = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (RP == AW'(i)) begin
`ifdef REGFILE_PIPE_BYPASS_EN
            rd_data_p = wr_dec[i] ? LD_DATA : row_q[i];
`else
            rd_data_p = row_q[i];
`endif
            rd_pend_p = pend_next[i];
         end
         if (RQ == AW'(i)) begin
`ifdef REGFILE_PIPE_BYPASS_EN
            rd_data_q = wr_dec[i] ? LD_DATA : row_q[i];
`else
            rd_data_q = row_q[i];
`endif
            rd_pend_q = pend_next[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         pend     <= '0;
         PEND_CNT <= '0;
         DATAP    <= WIDTH'(RST_VAL);
         DATAQ    <= WIDTH'(RST_VAL);
         PENDP    <= 1'b0;
         PENDQ    <= 1'b0;
      end else begin
         pend     <= pend_next;
         PEND_CNT <= cnt_next;
         DATAP    <= rd_data_p;
         DATAQ    <= rd_data_q;
         PENDP    <= rd_pend_p;
         PENDQ    <= rd_pend_q;
      end
   end

endmodule

// File: tb/tb_regfile_pipe.sv
// Directed table-driven bench for regfile_pipe, plus a DEPTH=6 instance
// exercising out-of-range addresses.
module tb_regfile_pipe;

   typedef struct {
      logic        clr;
      logic        wr;
      logic [2:0]  wa;
      logic [12:0] ld;
      logic        rsv;
      logic [2:0]  rsv_a;
      logic [2:0]  rp;
      logic [2:0]  rq;
      logic [12:0] exp_p;
      logic        exp_pp;
      logic [12:0] exp_q;
      logic        exp_pq;
      logic [3:0]  exp_cnt;
   } vec_t;

   logic        clk;
   logic        clr, wr, rsv;
   logic [2:0]  rp, rq, wa, rsv_a;
   logic [12:0] ld_data;
   logic [12:0] datap, dataq;
   logic        pendp, pendq;
   logic [3:0]  pend_cnt;

   logic        s6_clr, s6_wr, s6_rsv;
   logic [2:0]  s6_rp, s6_rq, s6_wa, s6_rsv_a;
   logic [12:0] s6_ld;
   logic [12:0] s6_datap, s6_dataq;
   logic        s6_pendp, s6_pendq;
   logic [3:0]  s6_cnt;

   int num_compared;
   int num_mismatched;

   vec_t vecs[$];
   logic [12:0] exp_byp;

   regfile_pipe dut (
      .CLK(clk), .CLR(clr), .RP(rp), .RQ(rq), .WA(wa), .LD_DATA(ld_data),
      .WR(wr), .RSV(rsv), .RSV_A(rsv_a), .DATAP(datap), .DATAQ(dataq),
      .PENDP(pendp), .PENDQ(pendq), .PEND_CNT(pend_cnt)
   );

   regfile_pipe #(.WIDTH(13), .DEPTH(6)) dut6 (
      .CLK(clk), .CLR(s6_clr), .RP(s6_rp), .RQ(s6_rq), .WA(s6_wa), .LD_DATA(s6_ld),
      .WR(s6_wr), .RSV(s6_rsv), .RSV_A(s6_rsv_a), .DATAP(s6_datap), .DATAQ(s6_dataq),
      .PENDP(s6_pendp), .PENDQ(s6_pendq), .PEND_CNT(s6_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic c, input logic w, input logic [2:0] a,
                               input logic [12:0] d, input logic r, input logic [2:0] ra,
                               input logic [2:0] p, input logic [2:0] q,
                               input logic [12:0] ep, input logic epp,
                               input logic [12:0] eq, input logic epq,
                               input logic [3:0] ec);
      vec_t v;
      v.clr = c; v.wr = w; v.wa = a; v.ld = d; v.rsv = r; v.rsv_a = ra;
      v.rp = p; v.rq = q; v.exp_p = ep; v.exp_pp = epp; v.exp_q = eq;
      v.exp_pq = epq; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      num_compared++;
      if (act !== exp) begin
         num_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one vector, let one edge pass, then check the registered outputs
   task automatic applyStimulus(input vec_t v, input string tag);
      clr = v.clr; wr = v.wr; wa = v.wa; ld_data = v.ld;
      rsv = v.rsv; rsv_a = v.rsv_a; rp = v.rp; rq = v.rq;
      @(posedge clk);
      #1;
      checkOutput({tag, ".datap"}, 16'(datap),    16'(v.exp_p));
      checkOutput({tag, ".pendp"}, 16'(pendp),    16'(v.exp_pp));
      checkOutput({tag, ".dataq"}, 16'(dataq),    16'(v.exp_q));
      checkOutput({tag, ".pendq"}, 16'(pendq),    16'(v.exp_pq));
      checkOutput({tag, ".cnt"},   16'(pend_cnt), 16'(v.exp_cnt));
   endtask

   task automatic applyStimulus6(input logic c, input logic w, input logic [2:0] a,
                                 input logic [12:0] d, input logic r, input logic [2:0] ra,
                                 input logic [2:0] p, input logic [2:0] q,
                                 input logic [12:0] ep, input logic epp,
                                 input logic [12:0] eq, input logic epq,
                                 input logic [3:0] ec, input string tag);
      s6_clr = c; s6_wr = w; s6_wa = a; s6_ld = d; s6_rsv = r; s6_rsv_a = ra;
      s6_rp = p; s6_rq = q;
      @(posedge clk);
      #1;
      checkOutput({tag, ".datap"}, 16'(s6_datap), 16'(ep));
      checkOutput({tag, ".pendp"}, 16'(s6_pendp), 16'(epp));
      checkOutput({tag, ".dataq"}, 16'(s6_dataq), 16'(eq));
      checkOutput({tag, ".pendq"}, 16'(s6_pendq), 16'(epq));
      checkOutput({tag, ".cnt"},   16'(s6_cnt),   16'(ec));
   endtask

   initial begin
      num_compared   = 0;
      num_mismatched = 0;
      clr = 1'b1; wr = 1'b0; rsv = 1'b0; rp = '0; rq = '0; wa = '0; rsv_a = '0; ld_data = '0;
      s6_clr = 1'b1; s6_wr = 1'b0; s6_rsv = 1'b0; s6_rp = '0; s6_rq = '0;
      s6_wa = '0; s6_rsv_a = '0; s6_ld = '0;

      //           clr wr wa  ld       rsv ra  rp  rq  exp_p    pp exp_q    pq cnt
      vecs.push_back(mk(1, 0, 0, 13'h0,    0, 0, 0, 0, 13'h0,    0, 13'h0,    0, 0));
      vecs.push_back(mk(1, 0, 0, 13'h0,    0, 0, 0, 0, 13'h0,    0, 13'h0,    0, 0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 0, 0, 13'h0, 0, 0, 3'(i), 3'(7 - i), 13'h0, 0, 13'h0, 0, 0));
      vecs.push_back(mk(0, 1, 3, 13'h1ABC, 0, 0, 0, 0, 13'h0,    0, 13'h0,    0, 0));
      vecs.push_back(mk(0, 0, 0, 13'h0,    0, 0, 3, 3, 13'h1ABC, 0, 13'h1ABC, 0, 0));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 2, 2, 5, 13'h0,    1, 13'h0,    0, 1));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 5, 2, 5, 13'h0,    1, 13'h0,    1, 2));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 5, 2, 5, 13'h0,    1, 13'h0,    1, 2));
      vecs.push_back(mk(0, 1, 5, 13'h0555, 0, 0, 2, 3, 13'h0,    1, 13'h1ABC, 0, 1));
      vecs.push_back(mk(0, 0, 0, 13'h0,    0, 0, 2, 5, 13'h0,    1, 13'h0555, 0, 1));
      vecs.push_back(mk(0, 1, 2, 13'h0222, 1, 2, 5, 3, 13'h0555, 0, 13'h1ABC, 0, 1));
      vecs.push_back(mk(0, 0, 0, 13'h0,    0, 0, 2, 2, 13'h0222, 1, 13'h0222, 1, 1));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 7, 7, 6, 13'h0,    1, 13'h0,    0, 2));
      vecs.push_back(mk(0, 1, 7, 13'h1777, 1, 6, 3, 5, 13'h1ABC, 0, 13'h0555, 0, 2));
      vecs.push_back(mk(0, 0, 0, 13'h0,    0, 0, 7, 6, 13'h1777, 0, 13'h0,    1, 2));
      vecs.push_back(mk(0, 1, 3, 13'h0333, 0, 0, 4, 0, 13'h0,    0, 13'h0,    0, 2));
      vecs.push_back(mk(0, 1, 0, 13'h1FFF, 0, 0, 7, 2, 13'h1777, 0, 13'h0222, 1, 2));
      vecs.push_back(mk(0, 0, 0, 13'h0,    0, 0, 0, 3, 13'h1FFF, 0, 13'h0333, 0, 2));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 0, 0, 0, 13'h1FFF, 1, 13'h1FFF, 1, 3));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 1, 1, 1, 13'h0,    1, 13'h0,    1, 4));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 3, 3, 3, 13'h0333, 1, 13'h0333, 1, 5));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 4, 4, 4, 13'h0,    1, 13'h0,    1, 6));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 5, 5, 5, 13'h0555, 1, 13'h0555, 1, 7));
      vecs.push_back(mk(0, 0, 0, 13'h0,    1, 7, 7, 7, 13'h1777, 1, 13'h1777, 1, 8));
      vecs.push_back(mk(1, 1, 1, 13'h1111, 1, 1, 0, 5, 13'h0,    0, 13'h0,    0, 0));
      vecs.push_back(mk(0, 0, 0, 13'h0,    0, 0, 1, 0, 13'h0,    0, 13'h0,    0, 0));

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i], $sformatf("vec%0d", i));

      // Write and read the same address in one cycle: bypass vs old value
`ifdef REGFILE_PIPE_BYPASS_EN
      exp_byp = 13'h1ABC;
`else
      exp_byp = 13'h0;
`endif
      applyStimulus(mk(0, 1, 3, 13'h1ABC, 0, 0, 3, 3, exp_byp,  0, exp_byp,  0, 0), "same_cyc");
      applyStimulus(mk(0, 0, 0, 13'h0,    0, 0, 3, 3, 13'h1ABC, 0, 13'h1ABC, 0, 0), "next_cyc");

      // DEPTH=6 instance: addresses 6 and 7 are out of range
      applyStimulus6(1, 0, 0, 13'h0,    0, 0, 0, 0, 13'h0,    0, 13'h0,    0, 0, "d6_rst");
      applyStimulus6(0, 1, 7, 13'h0777, 0, 0, 0, 0, 13'h0,    0, 13'h0,    0, 0, "d6_wr7");
      applyStimulus6(0, 0, 0, 13'h0,    0, 0, 7, 5, 13'h0,    0, 13'h0,    0, 0, "d6_rd7");
      applyStimulus6(0, 1, 5, 13'h0555, 1, 4, 4, 0, 13'h0,    1, 13'h0,    0, 1, "d6_wr5");
      applyStimulus6(0, 0, 0, 13'h0,    1, 6, 6, 5, 13'h0,    0, 13'h0555, 0, 1, "d6_rsv6");
      applyStimulus6(0, 1, 6, 13'h0666, 1, 7, 7, 4, 13'h0,    0, 13'h0,    1, 1, "d6_wr6");
      applyStimulus6(0, 0, 0, 13'h0,    0, 0, 6, 7, 13'h0,    0, 13'h0,    0, 1, "d6_rd67");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
